// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appending the 0x80 marker, zero fill and the 64-bit bit length.
module sha1_pad #(
  parameter int unsigned N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [N-1:0]  din,
  input  logic          din_last,
  input  logic [2:0]    din_bytes,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [511:0]  blk,
  output logic          blk_last
);

  localparam int unsigned W     = 32;
  localparam int unsigned WORDS = 16;
  localparam logic [W-1:0] MARK = 32'h8000_0000;

  typedef enum logic [1:0] {FILL, PAD, EMIT, EXTRA} state_t;

  state_t       state_q, state_n;
  logic [W-1:0] mem_q [WORDS];
  logic [3:0]   wi_q;
  logic [4:0]   pfree_q;
  logic [63:0]  len_q;
  logic         carry80_q;
  logic         extra_q;
  logic         last_q;

  logic         acc;
  logic [2:0]   nbytes;
  logic [6:0]   add_bits;
  logic [W-1:0] tail_word;

  // Handshake decode, byte clamp and tail-word masking with the 0x80 marker
  always_comb begin
    acc      = din_valid && (state_q == FILL);
    nbytes   = (din_bytes > 3'd4) ? 3'd4 : din_bytes;
    add_bits = din_last ? {1'b0, nbytes, 3'b000} : 7'd32;
    case (nbytes)
      3'd0:    tail_word = MARK;
      3'd1:    tail_word = {din[31:24], 24'h80_0000};
      3'd2:    tail_word = {din[31:16], 16'h8000};
      3'd3:    tail_word = {din[31:8], 8'h80};
      default: tail_word = din;
    endcase
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      FILL:  if (acc) state_n = din_last ? PAD : ((wi_q == 4'd15) ? EMIT : FILL);
      PAD:   state_n = EMIT;
      EMIT:  if (blk_ready) state_n = extra_q ? EXTRA : FILL;
      EXTRA: state_n = EMIT;
      default: state_n = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_n;
  end

  // Buffer, counters and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      din_ready <= 1'b1;
      blk_valid <= 1'b0;
      wi_q      <= '0;
      pfree_q   <= '0;
      len_q     <= '0;
      carry80_q <= 1'b0;
      extra_q   <= 1'b0;
      last_q    <= 1'b0;
      for (int i = 0; i < int'(WORDS); i++) mem_q[i] <= '0;
    end else begin
      din_ready <= (state_n == FILL);
      blk_valid <= (state_n == EMIT);
      case (state_q)
        FILL: begin
          if (acc) begin
            len_q <= len_q + 64'(add_bits);
            if (!din_last) begin
              mem_q[wi_q] <= din;
              if (wi_q == 4'd15) begin
                wi_q   <= '0;
                last_q <= 1'b0;
              end else begin
                wi_q <= wi_q + 4'd1;
              end
            end else if (nbytes != 3'd4) begin
              mem_q[wi_q] <= tail_word;
              pfree_q     <= 5'(wi_q) + 5'd1;
            end else begin
              mem_q[wi_q] <= din;
              if (wi_q != 4'd15) begin
                mem_q[wi_q + 4'd1] <= MARK;
                pfree_q            <= 5'(wi_q) + 5'd2;
              end else begin
                pfree_q   <= 5'd16;
                carry80_q <= 1'b1;
              end
            end
          end
        end
        PAD: begin
          for (int i = 0; i < int'(WORDS); i++)
            if (5'(i) >= pfree_q) mem_q[i] <= '0;
          // Length fits only if words 14 and 15 are still free
          if (pfree_q <= 5'd14) begin
            mem_q[14] <= len_q[63:32];
            mem_q[15] <= len_q[31:0];
            last_q    <= 1'b1;
            extra_q   <= 1'b0;
          end else begin
            last_q  <= 1'b0;
            extra_q <= 1'b1;
          end
        end
        EMIT: begin
          if (blk_ready) begin
            last_q <= 1'b0;
            if (extra_q) begin
              extra_q <= 1'b0;
            end else if (last_q) begin
              len_q     <= '0;
              wi_q      <= '0;
              carry80_q <= 1'b0;
            end
          end
        end
        EXTRA: begin
          for (int i = 0; i < int'(WORDS); i++) mem_q[i] <= '0;
          mem_q[0]  <= carry80_q ? MARK : '0;
          mem_q[14] <= len_q[63:32];
          mem_q[15] <= len_q[31:0];
          last_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    blk = '0;
    for (int i = 0; i < int'(WORDS); i++) blk[(WORDS-1-i)*W +: W] = mem_q[i];
  end

  assign blk_last = last_q;

endmodule

// File: doc/sha1_pad.md
# sha1_pad

Message padder and block assembler that sits directly upstream of the SHA-1 message-schedule stage. It accepts a message as a stream of 32-bit big-endian words with a last-word byte count. It applies standard SHA-1 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It then presents complete 512-bit blocks to the compression core over a valid/ready handshake. The core latches each accepted block into the schedule stage's `din` input at t = 0.

## Interface
- `N`, 32, input word width; only 32 is supported.
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `din_valid`  input  1  upstream word valid.
- `din_ready`  output  1  padder can accept a word.
- `din`  input  N  message word; byte 0 is `din[31:24]`.
- `din_last`  input  1  this is the final word of the message.
- `din_bytes`  input  3  number of valid bytes in the word, 0..4.
  - Sampled only when `din_last` = 1; non-last words always count 4.
  - 0 is legal only with `din_last` (empty tail or empty message).
  - Values 5..7 are treated as 4.
- `blk_valid`  output  1  `blk` holds a complete padded block.
- `blk_ready`  input  1  downstream accepts the block.
- `blk`  output  512  block; word 0 is `blk[511:480]`.
- `blk_last`  output  1  `blk` is the final block of the message.

## Operation
**State**
- 16×32 buffer.
- Word index `wi` (4 bits).
- 64-bit bit-length counter `len`.
- `carry80` flag.
- FSM with states FILL, PAD, EMIT, EXTRA.

**Word acceptance**
- A word transfers when `din_valid & din_ready`.
- `din_ready` = 1 only in FILL.
- Each transfer writes `buf[wi]` and adds 32, or `din_bytes*8` for a last word, to `len`.
- `len` is modulo 2^64.

**FILL, non-last word**
- If `wi` = 15, go to EMIT with `blk_last`=0 and `wi` ← 0.
- Otherwise `wi` ← `wi`+1.

**FILL, last word with b = `din_bytes`**
- If b < 4: bytes ≥ b of the word are forced to 0 and byte b is set to 0x80 (data bits beyond b are ignored). The first free word is p = `wi`+1.
- If b = 4: the word is stored unmodified and p = `wi`+1. If `wi` < 15, `buf[wi+1]` ← 0x80000000 and p = `wi`+2. If `wi` = 15, `carry80` ← 1.
- Go to PAD.

**PAD (one cycle)**
- Zero words p..15.
- If p ≤ 14: words 14,15 ← `len`, and go to EMIT with `blk_last`=1.
- Otherwise go to EMIT with `blk_last`=0 and an extra block pending.

**EMIT**
- `blk_valid`=1; `blk` and `blk_last` are held stable until `blk_ready`.
- On handshake:
  - If an extra block is pending, go to EXTRA.
  - Else if `blk_last`=1, clear `len`, `wi` and `carry80`, then go to FILL.
  - Else go to FILL.

**EXTRA (one cycle)**
- Buffer ← zeros, with word 0 = 0x80000000 if `carry80`.
- Words 14,15 ← `len`.
- Go to EMIT with `blk_last`=1.

**Rules**
- The word count is not bounded except by `len` wrap.
- There is no input/output overlap: `din_ready`=0 from PAD through the end of EMIT.

## Timing
**Reset**
- Effective on the clock edge where `rst`=1.
- After reset: `din_ready`=1 (FILL), `blk_valid`=0, `blk_last`=0, `blk`=0, `len`=0, `wi`=0, `carry80`=0.
- Reset mid-message or mid-EMIT discards all state; no partial block is ever emitted.

**Latency**
- 16th non-last word accepted at edge k → `blk_valid`=1 from edge k+1.
- Last word accepted at edge k → `blk_valid`=1 from edge k+2 (through PAD).
- Extra block: `blk_valid` drops for exactly one cycle (EXTRA) after the first handshake, then reasserts.

**Throughput**
- Full blocks: 16 accept cycles plus ≥1 EMIT cycle per block.
- `blk_ready` held high → EMIT lasts exactly 1 cycle.

**Other rules**
- `din_valid` with `din_ready`=0 is ignored; upstream must hold its word.
- Simultaneous `din_valid` and `blk_ready` in EMIT: only the block handshake occurs, and the word is accepted no earlier than the next cycle.

## Test plan
1. **Message "abc"**
   - Stimulus: after reset, one word 0x61626300 with `din_last`=1, `din_bytes`=3; `blk_ready`=1.
   - Required: one block, word0=0x61626380, words 1..14 = 0, word15=0x00000018, `blk_last`=1, `blk_valid` two cycles after acceptance.
2. **Empty message**
   - Stimulus: `din_last`=1, `din_bytes`=0, `din`=0xFFFFFFFF.
   - Required: word0=0x80000000, all other words 0, length 0, `blk_last`=1.
3. **56-byte message**
   - Stimulus: 14 words, last with `din_bytes`=4.
   - Required: block 1 has data in words 0..13, word14=0x80000000, word15=0, `blk_last`=0. After one gap cycle, block 2 is all zero except word15=0x000001C0, `blk_last`=1.
4. **64-byte message**
   - Stimulus: 16 words, last with `din_bytes`=4.
   - Required: block 1 is the raw data with `blk_last`=0. Block 2 has word0=0x80000000, word15=0x00000200, `blk_last`=1.
5. **Backpressure**
   - Stimulus: hold `blk_ready`=0 for 5 cycles in EMIT while `din_valid`=1.
   - Required: `blk` and `blk_last` stable, `din_ready`=0 throughout, no word lost after release.
6. **Reset mid-message**
   - Stimulus: assert `rst` after 7 words, then send "abc".
   - Required: output identical to scenario 1; the earlier words leave no trace in `len` or `blk`.
